// File: rtl/alu_ctrl.sv
// Instruction sequencer for the 8-bit ALU: fetches bytes over valid/ready, reads a 4-entry
// register file, drives the combinational ALU, writes back, and emits output bytes.
module alu_ctrl #(
    parameter int unsigned       DATA_W   = 8,
    parameter logic [DATA_W-1:0] REG_INIT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instr_valid,
    input  logic [DATA_W-1:0] instr_data,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [1:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    input  logic              alu_neg,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    input  logic              out_ready,
    output logic              flag_z,
    output logic              flag_n,
    output logic              busy
);

    typedef enum logic [1:0] {
        StFetch,
        StImm,
        StExec,
        StOut
    } state_e;

    localparam logic [1:0] ClsAlu = 2'b00;
    localparam logic [1:0] ClsLdi = 2'b01;
    localparam logic [1:0] ClsOut = 2'b10;
    localparam logic [1:0] ClsTst = 2'b11;

    state_e            state;
    logic [DATA_W-1:0] regs [4];
    logic [1:0]        rd;
    logic              tst;

    logic [1:0] dec_cls;
    logic [1:0] dec_aop;
    logic [1:0] dec_rd;
    logic [1:0] dec_rs;

    assign dec_cls = instr_data[7:6];
    assign dec_aop = instr_data[5:4];
    assign dec_rd  = instr_data[3:2];
    assign dec_rs  = instr_data[1:0];

    assign instr_ready = (state == StFetch) || (state == StImm);
    assign busy        = (state != StFetch);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StFetch;
            for (int i = 0; i < 4; i++) begin
                regs[i] <= REG_INIT;
            end
            rd        <= 2'b00;
            tst       <= 1'b0;
            flag_z    <= 1'b0;
            flag_n    <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            alu_a     <= '0;
            alu_b     <= '0;
            alu_op    <= 2'b00;
        end else begin
            unique case (state)
                StFetch: begin
                    if (instr_valid) begin
                        rd <= dec_rd;
                        unique case (dec_cls)
                            ClsAlu, ClsTst: begin
                                // Operands are latched here so the ALU sees stable inputs in EXEC.
                                alu_a  <= regs[dec_rd];
                                alu_b  <= regs[dec_rs];
                                alu_op <= dec_aop;
                                tst    <= (dec_cls == ClsTst);
                                state  <= StExec;
                            end
                            ClsLdi: begin
                                state <= StImm;
                            end
                            ClsOut: begin
                                out_valid <= 1'b1;
                                out_data  <= regs[dec_rs];
                                state     <= StOut;
                            end
                            default: state <= StFetch;
                        endcase
                    end
                end
                StImm: begin
                    if (instr_valid) begin
                        regs[rd] <= instr_data;
                        state    <= StFetch;
                    end
                end
                StExec: begin
                    flag_z <= alu_zero;
                    flag_n <= alu_neg;
                    if (!tst) begin
                        regs[rd] <= alu_result;
                    end
                    state <= StFetch;
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= StFetch;
                    end
                end
                default: state <= StFetch;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl.sv
// Directed-vector bench for alu_ctrl with a behavioural 8-bit ALU attached to its operand ports.
module tb_alu_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       instr_valid = 1'b0;
    logic [7:0] instr_data = 8'h00;
    logic       instr_ready;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [1:0] alu_op;
    logic [7:0] alu_result;
    logic       alu_zero;
    logic       alu_neg;
    logic       out_valid;
    logic [7:0] out_data;
    logic       out_ready = 1'b1;
    logic       flag_z;
    logic       flag_n;
    logic       busy;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    always_comb begin
        alu_result = 8'h00;
        case (alu_op)
            2'b00:   alu_result = alu_a + alu_b;
            2'b01:   alu_result = alu_a - alu_b;
            2'b10:   alu_result = alu_a & alu_b;
            default: alu_result = alu_a ^ alu_b;
        endcase
    end
    assign alu_zero = (alu_result == 8'h00);
    assign alu_neg  = alu_result[7];

    alu_ctrl #(
        .DATA_W  (8),
        .REG_INIT(8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .instr_data (instr_data),
        .instr_ready(instr_ready),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_op     (alu_op),
        .alu_result (alu_result),
        .alu_zero   (alu_zero),
        .alu_neg    (alu_neg),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_ready  (out_ready),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Presents one byte and returns #1 after the edge that transfers it.
    task automatic send(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        instr_valid = 1'b1;
        instr_data  = b;
        while (!instr_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!instr_ready) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        instr_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (busy && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (busy) check("idle_timeout", 32'd0, 32'd1);
    endtask

    task automatic ldi(input logic [1:0] r, input logic [7:0] v);
        send({2'b01, 2'b00, r, 2'b00});
        send(v);
    endtask

    // Reads a register by issuing OUT with out_ready held high.
    task automatic rd_reg(input logic [1:0] r, output logic [7:0] v);
        int n = 0;
        send({2'b10, 4'b0000, r});
        @(negedge clk);
        while (!out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!out_valid) check("out_timeout", 32'd0, 32'd1);
        v = out_data;
        @(posedge clk);
        #1;
    endtask

    logic [7:0] v;

    initial begin
        // Reset state
        #12;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'h00);
        check("rst_flag_z", 32'(flag_z), 32'd0);
        check("rst_flag_n", 32'(flag_n), 32'd0);
        check("rst_alu_a", 32'(alu_a), 32'h00);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_ready", 32'(instr_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: 5 + 3, checking the two-cycle ALU timing
        ldi(2'd0, 8'h05);
        ldi(2'd1, 8'h03);
        send(8'h01);
        check("t1_exec_busy", 32'(busy), 32'd1);
        check("t1_exec_ready", 32'(instr_ready), 32'd0);
        check("t1_alu_a", 32'(alu_a), 32'h05);
        check("t1_alu_b", 32'(alu_b), 32'h03);
        @(posedge clk);
        #1;
        check("t1_done_busy", 32'(busy), 32'd0);
        check("t1_flag_z", 32'(flag_z), 32'd0);
        check("t1_flag_n", 32'(flag_n), 32'd0);
        send(8'h80);
        check("t1_out_valid", 32'(out_valid), 32'd1);
        check("t1_out_data", 32'(out_data), 32'h08);
        wait_idle();

        // 2: 7F + 01 wraps negative
        ldi(2'd2, 8'h7F);
        ldi(2'd3, 8'h01);
        send(8'h0B);
        wait_idle();
        check("t2_flag_n", 32'(flag_n), 32'd1);
        check("t2_flag_z", 32'(flag_z), 32'd0);
        rd_reg(2'd2, v);
        check("t2_r2", 32'(v), 32'h80);

        // 3: xor self clears; TST sets Z without writeback
        ldi(2'd1, 8'h5A);
        send(8'h35);
        wait_idle();
        check("t3_xor_z", 32'(flag_z), 32'd1);
        check("t3_xor_n", 32'(flag_n), 32'd0);
        rd_reg(2'd1, v);
        check("t3_r1", 32'(v), 32'h00);
        send(8'h0B);  // R2 = 80 + 01 = 81, clears Z
        wait_idle();
        check("t3_pre_z", 32'(flag_z), 32'd0);
        check("t3_pre_n", 32'(flag_n), 32'd1);
        ldi(2'd0, 8'h01);
        send(8'hD0);
        wait_idle();
        check("t3_tst_z", 32'(flag_z), 32'd1);
        check("t3_tst_n", 32'(flag_n), 32'd0);
        rd_reg(2'd0, v);
        check("t3_r0_kept", 32'(v), 32'h01);

        // 4: OUT stall with a pending instruction byte
        out_ready = 1'b0;
        send(8'h82);
        instr_valid = 1'b1;
        instr_data  = 8'h40;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t4_stall_valid", 32'(out_valid), 32'd1);
            check("t4_stall_data", 32'(out_data), 32'h81);
            check("t4_stall_ready", 32'(instr_ready), 32'd0);
        end
        out_ready   = 1'b1;
        instr_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t4_released", 32'(out_valid), 32'd0);
        check("t4_fetch", 32'(busy), 32'd0);
        rd_reg(2'd0, v);
        check("t4_r0_kept", 32'(v), 32'h01);

        // 5: LDI header then gap
        send(8'h4C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t5_imm_busy", 32'(busy), 32'd1);
            check("t5_imm_ready", 32'(instr_ready), 32'd1);
        end
        send(8'hC4);
        rd_reg(2'd3, v);
        check("t5_r3", 32'(v), 32'hC4);

        // 6a: reset mid-LDI
        send(8'h40);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("t6a_busy", 32'(busy), 32'd0);
        check("t6a_flag_z", 32'(flag_z), 32'd0);
        check("t6a_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        rd_reg(2'd0, v);
        check("t6a_r0", 32'(v), 32'h00);

        // 6b: reset during OUT stall
        out_ready = 1'b0;
        send(8'h83);
        @(negedge clk);
        check("t6b_stalled", 32'(out_valid), 32'd1);
        rst = 1'b1;
        #1;
        check("t6b_out_valid", 32'(out_valid), 32'd0);
        check("t6b_out_data", 32'(out_data), 32'h00);
        check("t6b_ready", 32'(instr_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        rd_reg(2'd3, v);
        check("t6b_r3", 32'(v), 32'h00);
        rd_reg(2'd2, v);
        check("t6b_r2", 32'(v), 32'h00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
